// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// the default reset PC and the MIPS instruction field slice positions.
package fetch_pkg;

   typedef enum logic {
      S_REQ  = 1'b0,   // request outstanding to instruction memory
      S_EXEC = 1'b1    // instr latched, decoder/datapath acting on it
   } state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;
   localparam int IMM_W  = 16;
   localparam int JIDX_W = 26;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection for the fetch stage.
// Ports:
//   pc, instr                 : current instruction address and word
//   BranchE, BranchNE, J, Jal : decoder control for the current instr
//   zero                      : ALU equality result
//   next_pc                   : jump target, taken-branch target or pc+4
//   link_addr                 : pc+4, the return address for jal
module next_pc_logic
   import fetch_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   input  logic        BranchE,
   input  logic        BranchNE,
   input  logic        J,
   input  logic        Jal,
   input  logic        zero,
   output logic [31:0] next_pc,
   output logic [31:0] link_addr
);

   logic [31:0] pc4;
   logic [31:0] imm_ext;
   logic [31:0] btarget;
   logic [31:0] jtarget;
   logic        taken;
   // opcode bits are the decoder's business, not ours
   logic        unused_opc;

   assign unused_opc = ^instr[OPC_HI:OPC_LO];

   assign pc4     = pc + 32'd4;
   assign imm_ext = {{(32-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
   assign btarget = pc4 + (imm_ext << 2);
   // jump stays inside the 256MB region of the delay-slot address
   assign jtarget = {pc4[31:28], instr[JIDX_W-1:0], 2'b00};
   assign taken   = (BranchE & zero) | (BranchNE & ~zero);

   always_comb begin
      next_pc = pc4;
      if (J | Jal)
         next_pc = jtarget;
      else if (taken)
         next_pc = btarget;
   end

   assign link_addr = pc4;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, fetches from instruction memory over a
// req/ack handshake, latches the instruction for the decoder and advances
// the PC from the decoder's branch/jump controls once the instruction
// leaves S_EXEC.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   imem_req/addr/ack/rdata     : instruction memory handshake
//   instr, opcode, instr_valid  : latched instruction to the decoder
//   pc, link_addr               : current address and pc+4
//   stall                       : downstream hold while executing
//   BranchE/BranchNE/J/Jal/zero : next-PC controls for the current instr
//   retired                     : completed instruction count (wraps)
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr,
   output logic [5:0]        opcode,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] link_addr,
   input  logic              stall,
   input  logic              BranchE,
   input  logic              BranchNE,
   input  logic              J,
   input  logic              Jal,
   input  logic              zero,
   output logic [31:0]       retired
);

   state_t            state, state_n;
   logic [ADDR_W-1:0] pc_n;
   logic [31:0]       instr_n;
   logic [31:0]       retired_n;
   logic [ADDR_W-1:0] next_pc;

   next_pc_logic u_next_pc (
      .pc        (pc),
      .instr     (instr),
      .BranchE   (BranchE),
      .BranchNE  (BranchNE),
      .J         (J),
      .Jal       (Jal),
      .zero      (zero),
      .next_pc   (next_pc),
      .link_addr (link_addr)
   );

   always_comb begin
      state_n   = state;
      pc_n      = pc;
      instr_n   = instr;
      retired_n = retired;
      unique case (state)
         S_REQ: begin
            if (imem_ack) begin
               instr_n = imem_rdata;
               state_n = S_EXEC;
            end
         end
         S_EXEC: begin
            // ack here is ignored; only S_REQ accepts a returned word
            if (!stall) begin
               pc_n      = next_pc;
               retired_n = retired + 32'd1;
               state_n   = S_REQ;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_REQ;
         pc      <= RESET_PC;
         instr   <= '0;
         retired <= '0;
      end else begin
         state   <= state_n;
         pc      <= pc_n;
         instr   <= instr_n;
         retired <= retired_n;
      end
   end

   // state already sits in S_REQ during reset; gate req so memory sees
   // nothing until reset is released
   assign imem_req    = rst_n & (state == S_REQ);
   assign imem_addr   = pc;
   assign instr_valid = (state == S_EXEC);
   assign opcode      = instr[OPC_HI:OPC_LO];

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] link_addr;
   logic        stall;
   logic        BranchE, BranchNE, J, Jal, zero;
   logic [31:0] retired;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] exp_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_ret;

   instr_fetch #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
      .pc(pc), .link_addr(link_addr), .stall(stall),
      .BranchE(BranchE), .BranchNE(BranchNE), .J(J), .Jal(Jal), .zero(zero),
      .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One full fetch/execute: check the scoreboarded address, hold ack off
   // for dly cycles, return rdata, stall for stl cycles, then retire with
   // the given controls and push the modelled next address.
   task automatic serve(input logic [31:0] rdata, input int dly, input int stl,
                        input logic be, input logic bne, input logic jj,
                        input logic jl, input logic z);
      logic [31:0] exp_a, p4, nxt;
      int          off;
      if (exp_q.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
         exp_a = m_pc;
      end else
         exp_a = exp_q.pop_front();
      chk("req", {31'd0, imem_req}, 32'd1);
      chk("addr", imem_addr, exp_a);
      chk("ival_req", {31'd0, instr_valid}, 32'd0);
      for (int i = 0; i < dly; i++) begin
         tick;
         chk("req_hold", {31'd0, imem_req}, 32'd1);
         chk("addr_hold", imem_addr, exp_a);
         chk("ival_wait", {31'd0, instr_valid}, 32'd0);
      end
      imem_ack = 1'b1;
      imem_rdata = rdata;
      tick;
      imem_ack = 1'b0;
      chk("ival_exec", {31'd0, instr_valid}, 32'd1);
      chk("req_exec", {31'd0, imem_req}, 32'd0);
      chk("instr", instr, rdata);
      chk("opcode", {26'd0, opcode}, {26'd0, rdata[31:26]});
      chk("pc", pc, m_pc);
      chk("link", link_addr, m_pc + 32'd4);
      BranchE = be; BranchNE = bne; J = jj; Jal = jl; zero = z;
      for (int i = 0; i < stl; i++) begin
         stall = 1'b1;
         imem_ack = 1'b1;            // must be ignored outside S_REQ
         imem_rdata = ~rdata;
         tick;
         chk("stl_pc", pc, m_pc);
         chk("stl_instr", instr, rdata);
         chk("stl_ret", retired, m_ret);
         chk("stl_ival", {31'd0, instr_valid}, 32'd1);
      end
      imem_ack = 1'b0;
      stall = 1'b0;
      p4 = m_pc + 32'd4;
      off = int'($signed(rdata[15:0])) * 4;
      if (jj || jl)
         nxt = {p4[31:28], rdata[25:0], 2'b00};
      else if ((be && z) || (bne && !z))
         nxt = p4 + off;
      else
         nxt = p4;
      exp_q.push_back(nxt);
      tick;
      m_pc = nxt;
      m_ret = m_ret + 32'd1;
      chk("retired", retired, m_ret);
      BranchE = 0; BranchNE = 0; J = 0; Jal = 0; zero = 0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
      chk({tag, "_ival"}, {31'd0, instr_valid}, 32'd0);
      chk({tag, "_pc"}, pc, 32'h0);
      chk({tag, "_instr"}, instr, 32'h0);
      chk({tag, "_ret"}, retired, 32'h0);
   endtask

   task automatic release_reset;
      @(negedge clk);
      rst_n = 1'b1;
      tick;
      exp_q.delete();
      exp_q.push_back(32'h0);
      m_pc = 32'h0;
      m_ret = 32'h0;
   endtask

   localparam logic [31:0] NOP = 32'h0000_0000;

   function automatic logic [31:0] jmp(input logic [25:0] idx);
      return {6'h02, idx};
   endfunction

   function automatic logic [31:0] beq(input logic [15:0] imm);
      return {6'h04, 10'd0, imm};
   endfunction

   initial begin
      rst_n = 1'b0; imem_ack = 0; imem_rdata = 0; stall = 0;
      BranchE = 0; BranchNE = 0; J = 0; Jal = 0; zero = 0;
      m_pc = 0; m_ret = 0;
      #12;
      check_reset_vals("rst");
      release_reset;

      // sequential NOPs, ack in first request cycle
      serve(NOP, 0, 0, 0, 0, 0, 0, 0);
      serve(NOP, 0, 0, 0, 0, 0, 0, 0);
      serve(NOP, 0, 0, 0, 0, 0, 0, 0);
      chk("ret3", retired, 32'd3);
      chk("addr_c", imem_addr, 32'h0000_000C);

      // jump to 0x20, then reset while that fetch is outstanding
      serve(jmp(26'h8), 0, 0, 0, 0, 1, 0, 0);
      chk("addr_20", imem_addr, 32'h0000_0020);
      void'(exp_q.pop_front());
      #2 rst_n = 1'b0;
      #1 check_reset_vals("midrst");
      tick;
      release_reset;
      chk("post_rst_addr", imem_addr, 32'h0);
      chk("post_rst_ret", retired, 32'h0);

      // branch back to 0xFFFF_FFFC, then wrap with a slow, stalled NOP
      serve(beq(16'hFFFE), 0, 0, 1, 0, 0, 0, 1);
      chk("addr_top", imem_addr, 32'hFFFF_FFFC);
      serve(NOP, 3, 4, 0, 0, 0, 0, 0);
      chk("addr_wrap", imem_addr, 32'h0);

      // branch cases at pc=0x100
      serve(jmp(26'h40), 0, 0, 0, 0, 1, 0, 0);
      serve(beq(16'hFFFE), 0, 0, 1, 0, 0, 0, 1);
      chk("beq_taken", imem_addr, 32'h0000_00FC);
      serve(jmp(26'h40), 0, 0, 0, 0, 1, 0, 0);
      serve(beq(16'hFFFE), 0, 0, 1, 0, 0, 0, 0);
      chk("beq_not", imem_addr, 32'h0000_0104);
      serve(jmp(26'h40), 0, 0, 0, 0, 1, 0, 0);
      serve(beq(16'hFFFE), 0, 0, 0, 1, 0, 0, 0);
      chk("bne_taken", imem_addr, 32'h0000_00FC);

      // climb to 0x4000_0010 with max forward branches
      serve(jmp(26'h4), 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 8192; i++)
         serve(beq(16'h7FFF), 0, 0, 1, 0, 0, 0, 1);
      chk("chain", imem_addr, 32'h4000_0010);

      // jump beats a simultaneous taken branch
      serve(jmp(26'h40), 0, 0, 1, 0, 1, 0, 1);
      chk("j_wins", imem_addr, 32'h4000_0100);
      serve(jmp(26'h4), 0, 0, 0, 0, 1, 0, 0);
      chk("back_10", imem_addr, 32'h4000_0010);
      serve({6'h03, 26'h40}, 0, 0, 0, 0, 0, 1, 0);
      chk("jal", imem_addr, 32'h4000_0100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage for the 32-bit MIPS core, directly upstream of the opcode decoder. It holds the PC and issues requests to instruction memory with a req/ack handshake. It latches the returned word and presents opcode and fields to the decoder.
- It consumes the decoder's BranchE/BranchNE/J/Jal outputs plus the ALU zero flag to select the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- ADDR_W, 32, PC/address width; only 32 is supported.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  word address = pc, bits [1:0] always 0.
- imem_ack  in  1  response valid; imem_rdata is sampled in the same cycle.
- imem_rdata  in  32  fetched instruction.
- instr  out  32  latched instruction register.
- opcode  out  6  instr[31:26], drives the decoder.
- instr_valid  out  1  instr is current and executing.
- pc  out  32  address of the current instruction.
- link_addr  out  32  pc+4, the return address for jal.
- stall  in  1  downstream hold; freezes the stage in S_EXEC.
- BranchE, BranchNE, J, Jal  in  1 each  decoder outputs for the current instr.
- zero  in  1  ALU equality result for the current instr.
- retired  out  32  count of completed instructions.

Behaviour:
- Reset (async, rst_n=0) values:
  - pc=RESET_PC, instr=0, instr_valid=0, retired=0.
  - imem_req=0 while rst_n is low; state=S_REQ.
- Reset taken mid-operation discards any outstanding fetch. A late imem_ack that arrives after reset release in S_REQ is accepted as the RESET_PC fetch; memory must not ack stale requests across reset.
- S_REQ:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - On imem_ack=1: instr<=imem_rdata, go to S_EXEC.
  - Otherwise stay.
- S_EXEC:
  - imem_req=0, instr_valid=1. The decoder and datapath act on instr this cycle.
  - stall=1: hold pc, instr and state.
  - stall=0: pc<=next_pc, retired<=retired+1 (wraps at 2^32), go to S_REQ.
- imem_ack outside S_REQ is ignored.
- Minimum throughput is 2 cycles/instruction, when ack arrives in the first S_REQ cycle.
- next_pc (combinational, evaluated in S_EXEC):
  - pc4 = pc+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - btarget = pc4 + (sign_extend(instr[15:0]) << 2), modulo 2^32.
  - jtarget = {pc4[31:28], instr[25:0], 2'b00}.
  - taken = (BranchE & zero) | (BranchNE & ~zero).
  - Priority: J|Jal -> jtarget; else taken -> btarget; else pc4.
  - J and a branch asserted together: the jump wins.
- link_addr = pc4, valid whenever instr_valid=1.
- Control inputs and zero are don't-care outside S_EXEC.
- pc[1:0] are never nonzero: btarget and jtarget are word-aligned by construction.

Decomposition:
- Package fetch_pkg:
  - state encoding S_REQ / S_EXEC.
  - default RESET_PC.
  - field slices OPC_HI=31, OPC_LO=26, IMM_W=16, JIDX_W=26.
- Sub-module next_pc_logic, purely combinational:
  - inputs: pc, instr, BranchE, BranchNE, J, Jal, zero.
  - outputs: next_pc, link_addr.
- The top level holds the FSM, the pc/instr/retired registers and the handshake.

Test Plan:
- Reset then ack each request in its first cycle with NOPs (0x00000000), no control asserted -> imem_addr sequence 0x0,0x4,0x8; 2 cycles/instr; retired=3 after 3 S_EXEC exits.
- pc=0x100, instr imm=0xFFFE, BranchE=1, zero=1 -> next imem_addr=0x0FC. Same with zero=0 -> 0x104. BranchNE=1, zero=0 -> 0x0FC.
- pc=0x4000_0010, instr[25:0]=0x0000040, J=1 (also with BranchE=1, zero=1) -> imem_addr=0x4000_0100. Jal=1 -> same target and link_addr=0x4000_0014.
- Hold imem_ack low 3 cycles -> imem_req stays 1, addr stable, instr_valid=0. Then stall=1 for 4 cycles in S_EXEC -> pc, instr, retired frozen.
- pc=0xFFFF_FFFC, no branch -> next imem_addr=0x0000_0000.
- Assert rst_n=0 mid-S_REQ with addr 0x20 outstanding -> outputs return to reset values immediately. After release, first imem_addr=RESET_PC and retired=0.
